datapoint_memory_arbiter: RTL and testbench

- Shares the single-port datapoint memory (1024 x 18, synchronous read, 1-cycle latency, preloaded from the NN description table) among NUM_REQ requesters, such as neuron lanes and the host loader.
- Grants one access per cycle using round-robin priority.
- Supports locked bursts, where one requester keeps the grant across several beats.
- Returns read data to the originating requester exactly one cycle after the access is accepted.
- Sits between the neuron/loader request fabric and the memory's io_wrEna/io_Addr/io_dataIn/io_rdData pins.

---
 rtl/datapoint_memory_arbiter_pkg.sv | 18 +
 rtl/datapoint_memory_arbiter_if.sv | 33 +++
 rtl/datapoint_memory_arbiter_picker.sv | 24 ++
 rtl/datapoint_memory_arbiter.sv | 83 ++++++++
 tb/tb_datapoint_memory_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/datapoint_memory_arbiter_pkg.sv
// Shared constants and request bundle for the datapoint memory arbiter.
// No logic, so no latency or backpressure of its own.
package datapoint_memory_arbiter_pkg;

  localparam int DPM_ADDR_W  = 10;
  localparam int DPM_DATA_W  = 18;
  localparam int DPM_DEPTH   = 1024;
  localparam int DPM_NUM_REQ = 4;

  typedef struct packed {
    logic                  valid;
    logic                  wr;
    logic                  lock;
    logic [DPM_ADDR_W-1:0] addr;
    logic [DPM_DATA_W-1:0] data;
  } req_t;

endpackage

// File: rtl/datapoint_memory_arbiter_if.sv
// Request fabric plus memory pins. The arbiter side is the slave modport.
// Ready is a one-cycle grant; responses have no backpressure.
interface datapoint_memory_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 18
);
  logic [NUM_REQ-1:0]        io_req_valid;
  logic [NUM_REQ-1:0]        io_req_ready;
  logic [NUM_REQ-1:0]        io_req_wr;
  logic [NUM_REQ-1:0]        io_req_lock;
  logic [NUM_REQ*ADDR_W-1:0] io_req_addr;
  logic [NUM_REQ*DATA_W-1:0] io_req_data;
  logic [NUM_REQ-1:0]        io_resp_valid;
  logic [DATA_W-1:0]         io_resp_data;
  logic                      io_mem_wrEna;
  logic [ADDR_W-1:0]         io_mem_Addr;
  logic [DATA_W-1:0]         io_mem_dataIn;
  logic [DATA_W-1:0]         io_mem_rdData;
  logic                      io_owner_locked;

  modport slave (
    input  io_req_valid, io_req_wr, io_req_lock, io_req_addr, io_req_data, io_mem_rdData,
    output io_req_ready, io_resp_valid, io_resp_data, io_mem_wrEna, io_mem_Addr,
           io_mem_dataIn, io_owner_locked
  );

  modport master (
    output io_req_valid, io_req_wr, io_req_lock, io_req_addr, io_req_data, io_mem_rdData,
    input  io_req_ready, io_resp_valid, io_resp_data, io_mem_wrEna, io_mem_Addr,
           io_mem_dataIn, io_owner_locked
  );
endinterface

// File: rtl/datapoint_memory_arbiter_picker.sv
// Round-robin picker: first valid bit after ptr, wrapping. Purely combinational.
// No backpressure; the caller decides whether the grant is used.
module rr_priority_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grantIdx
);

  always_comb begin
    grant    = '0;
    grantIdx = '0;
    for (int k = 1; k <= N; k++) begin
      if (grant == '0 && valid[(int'(ptr) + k) % N]) begin
        grant[(int'(ptr) + k) % N] = 1'b1;
        grantIdx                   = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/datapoint_memory_arbiter.sv
// Round-robin arbiter with locked bursts for the single-port datapoint memory.
// Grant is same-cycle, read data returns one cycle later; responses cannot be stalled.
module datapoint_memory_arbiter
  import datapoint_memory_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DPM_NUM_REQ,
  parameter int ADDR_W  = DPM_ADDR_W,
  parameter int DATA_W  = DPM_DATA_W
) (
  input logic                       clock,
  input logic                       reset,
  datapoint_memory_arbiter_if.slave bus
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0]      rrPtr;
  logic [IW-1:0]      lockOwner;
  logic [IW-1:0]      respId;
  logic [IW-1:0]      rrIdx;
  logic [IW-1:0]      gntIdx;
  logic [IW-1:0]      selIdx;
  logic               lockActive;
  logic               respPending;
  logic [NUM_REQ-1:0] rrGrant;
  logic [NUM_REQ-1:0] grant;
  req_t               sel;

  rr_priority_picker #(.N(NUM_REQ), .IW(IW)) picker (
    .valid    (bus.io_req_valid),
    .ptr      (rrPtr),
    .grant    (rrGrant),
    .grantIdx (rrIdx)
  );

  // A held lock overrides round-robin even when the owner is idle.
  always_comb begin
    grant  = '0;
    gntIdx = rrIdx;
    if (reset) begin
      if (lockActive) begin
        grant  = (NUM_REQ'(1) << lockOwner) & bus.io_req_valid;
        gntIdx = lockOwner;
      end else begin
        grant  = rrGrant;
      end
    end
    // With no grant the mux parks on the last winner so the memory pins stay stable.
    selIdx    = (|grant) ? gntIdx : rrPtr;
    sel.valid = |grant;
    sel.wr    = bus.io_req_wr[selIdx];
    sel.lock  = bus.io_req_lock[selIdx];
    sel.addr  = bus.io_req_addr[int'(selIdx)*ADDR_W +: ADDR_W];
    sel.data  = bus.io_req_data[int'(selIdx)*DATA_W +: DATA_W];
  end

  assign bus.io_req_ready    = grant;
  assign bus.io_mem_wrEna    = sel.valid & sel.wr;
  assign bus.io_mem_Addr     = sel.addr;
  assign bus.io_mem_dataIn   = sel.data;
  assign bus.io_resp_valid   = respPending ? (NUM_REQ'(1) << respId) : '0;
  assign bus.io_resp_data    = bus.io_mem_rdData;
  assign bus.io_owner_locked = lockActive;

  always_ff @(posedge clock) begin
    if (!reset) begin
      rrPtr       <= IW'(NUM_REQ - 1);
      lockActive  <= 1'b0;
      lockOwner   <= '0;
      respPending <= 1'b0;
      respId      <= '0;
    end else begin
      respPending <= sel.valid & ~sel.wr;
      if (sel.valid) begin
        rrPtr      <= selIdx;
        lockActive <= sel.lock;
        respId     <= selIdx;
        if (sel.lock) lockOwner <= selIdx;
      end
    end
  end

endmodule

// File: tb/tb_datapoint_memory_arbiter.sv
// Directed bench for datapoint_memory_arbiter with a behavioural grant/response model
// checked every cycle, plus hand-computed expectations for each scenario.
module tb_datapoint_memory_arbiter;
  import datapoint_memory_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 18;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  datapoint_memory_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  datapoint_memory_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] tbl(input int i);
    return DW'(32'h10000 + i * 32'h111);
  endfunction

  // Preloaded single-port memory, synchronous read.
  logic [DW-1:0] mem [DPM_DEPTH];
  initial for (int i = 0; i < DPM_DEPTH; i++) mem[i] = tbl(i);
  always @(posedge clock) begin
    if (bus.io_mem_wrEna) mem[bus.io_mem_Addr] <= bus.io_mem_dataIn;
    bus.io_mem_rdData <= mem[bus.io_mem_Addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic setReq(input int i, input logic v, input logic w, input logic l,
                        input int a, input logic [DW-1:0] d);
    bus.io_req_valid[i]          = v;
    bus.io_req_wr[i]             = w;
    bus.io_req_lock[i]           = l;
    bus.io_req_addr[i*AW +: AW]  = AW'(a);
    bus.io_req_data[i*DW +: DW]  = d;
  endtask

  task automatic clearReqs();
    for (int i = 0; i < N; i++) setReq(i, 1'b0, 1'b0, 1'b0, 0, '0);
  endtask

  // Behavioural model: owner/last-winner integers, a shadow memory and a one-deep response slot.
  initial begin : scoreboard
    logic [DW-1:0] mm [DPM_DEPTH];
    int            last, owner, g, pendId;
    bit            pend, armed, rs;
    logic [DW-1:0] pendData;
    logic [N-1:0]  v, w, l;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i < DPM_DEPTH; i++) mm[i] = tbl(i);
    armed = 0; pend = 0; last = N - 1; owner = -1; pendId = 0; pendData = '0;
    a = '0; d = '0;
    forever begin
      @(negedge clock);
      rs = reset;
      v  = bus.io_req_valid;
      w  = bus.io_req_wr;
      l  = bus.io_req_lock;
      g  = -1;
      if (rs) begin
        if (owner >= 0) begin
          if (v[owner]) g = owner;
        end else begin
          for (int k = 1; k <= N; k++)
            if (g < 0 && v[(last + k) % N]) g = (last + k) % N;
        end
      end
      if (g >= 0) begin
        a = bus.io_req_addr[g*AW +: AW];
        d = bus.io_req_data[g*DW +: DW];
      end
      if (armed) begin
        check("sb_ready", 32'(bus.io_req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        check("sb_wrEna", 32'(bus.io_mem_wrEna), 32'((g >= 0) && w[g]));
        if (g >= 0) check("sb_addr", 32'(bus.io_mem_Addr), 32'(a));
        if (g >= 0 && w[g]) check("sb_dataIn", 32'(bus.io_mem_dataIn), 32'(d));
        check("sb_respValid", 32'(bus.io_resp_valid), pend ? (32'd1 << pendId) : 32'd0);
        if (pend) check("sb_respData", 32'(bus.io_resp_data), 32'(pendData));
        check("sb_locked", 32'(bus.io_owner_locked), 32'(owner >= 0));
      end
      @(posedge clock);
      if (!rs) begin
        last = N - 1; owner = -1; pend = 0; armed = 1;
      end else if (armed) begin
        pend = 0;
        if (g >= 0) begin
          last  = g;
          owner = l[g] ? g : -1;
          if (w[g]) mm[a] = d;
          else begin
            pend = 1; pendId = g; pendData = mm[a];
          end
        end
      end
    end
  end

  initial begin : stim
    logic [DW-1:0] exp4 [4];
    exp4 = '{18'h10000, 18'h10111, 18'h10222, 18'h10333};
    clearReqs();
    reset = 1'b0;

    // Reset: everyone requesting, req0 as a write, nothing may be granted.
    for (int i = 0; i < N; i++) setReq(i, 1'b1, 1'b0, 1'b0, i, '0);
    bus.io_req_wr[0] = 1'b1;
    tick();
    tick();
    @(negedge clock);
    check("rst_ready", 32'(bus.io_req_ready), 32'h0);
    check("rst_wrEna", 32'(bus.io_mem_wrEna), 32'h0);
    check("rst_respValid", 32'(bus.io_resp_valid), 32'h0);
    check("rst_locked", 32'(bus.io_owner_locked), 32'h0);
    tick();
    reset = 1'b1;
    bus.io_req_wr[0] = 1'b0;

    // Four concurrent reads drain in order 0..3 with responses one cycle behind.
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("rr_ready", 32'(bus.io_req_ready), (k < 4) ? (32'd1 << k) : 32'd0);
      if (k > 0) begin
        check("rr_respValid", 32'(bus.io_resp_valid), 32'd1 << (k - 1));
        check("rr_respData", 32'(bus.io_resp_data), 32'(exp4[k-1]));
      end
      tick();
      if (k < 4) bus.io_req_valid[k] = 1'b0;
    end

    // Write then read-back of the same address.
    setReq(1, 1'b1, 1'b1, 1'b0, 5, 18'h2ABCD);
    @(negedge clock);
    check("wr_ready", 32'(bus.io_req_ready), 32'h2);
    check("wr_wrEna", 32'(bus.io_mem_wrEna), 32'h1);
    check("wr_addr", 32'(bus.io_mem_Addr), 32'd5);
    tick();
    setReq(1, 1'b0, 1'b0, 1'b0, 0, '0);
    setReq(2, 1'b1, 1'b0, 1'b0, 5, '0);
    @(negedge clock);
    check("rd_ready", 32'(bus.io_req_ready), 32'h4);
    check("rd_wrEna", 32'(bus.io_mem_wrEna), 32'h0);
    tick();
    setReq(2, 1'b0, 1'b0, 1'b0, 0, '0);
    @(negedge clock);
    check("rd_respValid", 32'(bus.io_resp_valid), 32'h4);
    check("rd_respData", 32'(bus.io_resp_data), 32'h2ABCD);
    tick();

    // Three-beat locked burst from req0 while the others wait.
    setReq(0, 1'b1, 1'b0, 1'b1, 10, '0);
    @(negedge clock);
    check("lk_ready0", 32'(bus.io_req_ready), 32'h1);
    tick();
    for (int i = 1; i < N; i++) setReq(i, 1'b1, 1'b0, 1'b0, 40 + i, '0);
    setReq(0, 1'b1, 1'b0, 1'b1, 11, '0);
    @(negedge clock);
    check("lk_ready1", 32'(bus.io_req_ready), 32'h1);
    check("lk_locked1", 32'(bus.io_owner_locked), 32'h1);
    tick();
    setReq(0, 1'b1, 1'b0, 1'b0, 12, '0);
    @(negedge clock);
    check("lk_ready2", 32'(bus.io_req_ready), 32'h1);
    check("lk_locked2", 32'(bus.io_owner_locked), 32'h1);
    tick();
    bus.io_req_valid[0] = 1'b0;
    @(negedge clock);
    check("lk_after", 32'(bus.io_req_ready), 32'h2);
    check("lk_released", 32'(bus.io_owner_locked), 32'h0);
    tick();
    clearReqs();

    // Owner req2 goes idle while holding the lock; req0's write must stay blocked.
    setReq(2, 1'b1, 1'b0, 1'b1, 50, '0);
    @(negedge clock);
    check("hold_take", 32'(bus.io_req_ready), 32'h4);
    tick();
    setReq(2, 1'b0, 1'b0, 1'b1, 50, '0);
    setReq(0, 1'b1, 1'b1, 1'b0, 20, 18'h00777);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("hold_ready", 32'(bus.io_req_ready), 32'h0);
      check("hold_wrEna", 32'(bus.io_mem_wrEna), 32'h0);
      check("hold_locked", 32'(bus.io_owner_locked), 32'h1);
      tick();
    end
    setReq(2, 1'b1, 1'b0, 1'b0, 51, '0);
    @(negedge clock);
    check("hold_resume", 32'(bus.io_req_ready), 32'h4);
    tick();
    setReq(2, 1'b0, 1'b0, 1'b0, 0, '0);
    setReq(3, 1'b1, 1'b0, 1'b0, 52, '0);
    @(negedge clock);
    check("hold_next3", 32'(bus.io_req_ready), 32'h8);
    tick();
    setReq(3, 1'b0, 1'b0, 1'b0, 0, '0);
    @(negedge clock);
    check("hold_next0", 32'(bus.io_req_ready), 32'h1);
    check("hold_wr0", 32'(bus.io_mem_wrEna), 32'h1);
    tick();
    clearReqs();

    // Lone requester streaming reads: grant and response every cycle.
    setReq(3, 1'b1, 1'b0, 1'b0, 30, '0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      check("strm_ready", 32'(bus.io_req_ready), 32'h8);
      if (k > 0) begin
        check("strm_respValid", 32'(bus.io_resp_valid), 32'h8);
        check("strm_respData", 32'(bus.io_resp_data), 32'(tbl(30 + k - 1)));
      end
      tick();
      bus.io_req_addr[3*AW +: AW] = AW'(31 + k);
    end
    bus.io_req_valid[3] = 1'b0;
    @(negedge clock);
    check("strm_lastResp", 32'(bus.io_resp_valid), 32'h8);
    tick();

    // Locked read, then reset on the next cycle: response dropped, lock cleared.
    setReq(1, 1'b1, 1'b0, 1'b1, 60, '0);
    @(negedge clock);
    check("mr_ready", 32'(bus.io_req_ready), 32'h2);
    tick();
    reset = 1'b0;
    for (int i = 0; i < N; i++) setReq(i, 1'b1, 1'b0, 1'b0, 70 + i, '0);
    @(negedge clock);
    check("mr_forced", 32'(bus.io_req_ready), 32'h0);
    check("mr_respBefore", 32'(bus.io_resp_valid), 32'h2);
    check("mr_lockBefore", 32'(bus.io_owner_locked), 32'h1);
    tick();
    @(negedge clock);
    check("mr_respDropped", 32'(bus.io_resp_valid), 32'h0);
    check("mr_lockCleared", 32'(bus.io_owner_locked), 32'h0);
    tick();
    reset = 1'b1;
    @(negedge clock);
    check("mr_prio0", 32'(bus.io_req_ready), 32'h1);
    tick();
    clearReqs();
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
